pwm_softstart_gen: RTL
======================

// Module: pwm_softstart_gen
// PURPOSE
//  Audio PWM output stage, fed by the power-up reference block. Takes a 5-bit
//  duty target (pwm_ref) and produces a 2^WIDTH-slot PWM waveform. Applied duty
//  starts at 0 and soft-ramps toward the target to avoid speaker pops. After
//  lock it tracks target changes at period boundaries only (glitch-free).
// PARAMETERS
//  WIDTH     5   duty/counter width; period = 2^WIDTH ticks
//  PRESCALE  4   clk cycles per PWM tick (>=1)
//  RAMP_DIV  16  PWM periods per +/-1 duty step while ramping (>=1)
// PORTS
//  clk            in   1      system clock, all logic on posedge
//  reset_central  in   1      synchronous, active-high reset
//  en             in   1      1 = run; 0 = idle, output forced low
//  pwm_ref        in   WIDTH  duty target, unsigned, 0..2^WIDTH-1
//  pwm_out        out  1      PWM waveform, registered
//  period_start   out  1      1-cycle pulse when slot counter wraps to 0
//  duty_cur       out  WIDTH  duty applied in the current period
//  locked         out  1      1 = duty_cur has reached the target (TRACK)
// BEHAVIOUR
//  Reset (reset_central=1 at posedge): state=IDLE, prescaler=0, slot cnt=0,
//   period cnt pc=0, duty_cur=0, pwm_out=0, period_start=0, locked=0.
//   Applies mid-period too; waveform restarts from slot 0.
//  Tick: prescaler counts 0..PRESCALE-1; tick = (pre==PRESCALE-1).
//   PRESCALE=1 -> tick every cycle.
//  Slot cnt increments on tick, wraps 2^WIDTH-1 -> 0 (modulo, no saturation).
//   Wrap = period boundary. period_start=1 the cycle cnt becomes 0.
//  pwm_out <= (cnt < duty_cur), evaluated on the post-update values, so it is
//   registered with 1 cycle latency. Duty 0 -> constant 0; duty 2^WIDTH-1 ->
//   high (2^WIDTH-1) of 2^WIDTH slots. 100% duty is not reachable.
//  duty_cur changes only at period boundaries, never mid-period.
//  FSM:
//   IDLE : pre, cnt, pc, duty_cur held 0; pwm_out=0; locked=0.
//          en=1 -> RAMP on the next cycle; counting starts from slot 0.
//   RAMP : pc increments on each boundary. At a boundary with pc==RAMP_DIV-1:
//          duty_cur steps +1 toward pwm_ref (or -1 if above), pc<=0.
//          A boundary where duty_cur==pwm_ref -> TRACK, locked<=1, pc<=0.
//   TRACK: at each boundary, if |pwm_ref-duty_cur|<=1 then duty_cur<=pwm_ref.
//          Otherwise -> RAMP, locked<=0, pc<=0, duty_cur unchanged.
//   Any state, en=0 -> IDLE on the next cycle. All counters and duty_cur clear,
//          so there is no ramp-down.
//  pwm_ref is sampled only at boundaries; changes mid-period are ignored.
//  reset_central has priority over en. Difference is computed with WIDTH+1
//   bits, signed, so there is no wrap in the comparison.
// TESTING (bench uses PRESCALE=1, RAMP_DIV=2, WIDTH=5 unless noted)
//  1 reset_central=1 for 3 cycles with en=1, pwm_ref=6 -> all outputs 0;
//    release -> period_start first pulses 33 cycles later (IDLE->RAMP + 32).
//  2 en=1, pwm_ref=6 from reset -> duty_cur steps 1..6, one step per 2
//    periods. locked rises at the boundary where duty_cur is first seen ==6
//    (the 13th boundary). pwm_out then high 6 of every 32 cycles.
//  3 locked at 6, pwm_ref->7 mid-period -> no change until the next boundary,
//    then duty_cur=7, locked stays 1.
//  4 locked at 6, pwm_ref->20 -> locked=0 at the next boundary; ramp up to 20
//    at 1 step/2 periods; locked=1 again once 20 is reached.
//  5 pwm_ref=31 locked -> 31 high/1 low per period; pwm_ref=0 reached by ramp
//    -> pwm_out constant 0.
//  6 en drops mid-period at duty 12 -> next cycle pwm_out=0, duty_cur=0,
//    locked=0. en=1 again -> ramp restarts from 0. Repeat with PRESCALE=4:
//    period = 128 cycles.

Source files
------------

// File: rtl/pwm_softstart_gen.sv
// PWM output stage with soft-start: applied duty ramps from 0 toward the target,
// then tracks small target changes, always updating only at period boundaries.
//   state   | meaning
//   S_IDLE  | disabled, all counters and duty cleared, output low
//   S_RAMP  | stepping duty by one every RAMP_DIV periods toward pwm_ref
//   S_TRACK | locked; follows pwm_ref directly while it moves by at most one
module pwm_softstart_gen #(
   parameter int WIDTH    = 5,
   parameter int PRESCALE = 4,
   parameter int RAMP_DIV = 16
) (
   input  logic             clk,
   input  logic             reset_central,
   input  logic             en,
   input  logic [WIDTH-1:0] pwm_ref,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty_cur,
   output logic             locked
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PW-1:0]      PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [RW-1:0]      PC_LAST  = RW'(RAMP_DIV - 1);
   localparam logic [WIDTH-1:0]   CNT_LAST = '1;
   localparam logic signed [WIDTH:0] D_ONE  = 1;
   localparam logic signed [WIDTH:0] D_MONE = -1;

   typedef enum logic [1:0] {S_IDLE, S_RAMP, S_TRACK} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    pc_q, pc_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             ps_q, ps_d;
   logic             lock_q, lock_d;
   logic             tick, wrap;
   logic signed [WIDTH:0] diff;

   assign tick = (pre_q == PRE_LAST);
   assign wrap = tick && (cnt_q == CNT_LAST);
   // One extra bit so a full-scale target/duty gap never aliases.
   assign diff = $signed({1'b0, pwm_ref}) - $signed({1'b0, duty_q});

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      duty_d  = duty_q;
      lock_d  = lock_q;
      ps_d    = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
         pre_d   = '0;
         cnt_d   = '0;
         pc_d    = '0;
         duty_d  = '0;
         lock_d  = 1'b0;
      end else if (state_q == S_IDLE) begin
         state_d = S_RAMP;
      end else begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick) cnt_d = cnt_q + 1'b1;
         if (wrap) begin
            ps_d = 1'b1;
            if (state_q == S_TRACK) begin
               if ((diff >= D_MONE) && (diff <= D_ONE)) begin
                  duty_d = pwm_ref;
               end else begin
                  state_d = S_RAMP;
                  lock_d  = 1'b0;
                  pc_d    = '0;
               end
            end else if (diff == '0) begin
               state_d = S_TRACK;
               lock_d  = 1'b1;
               pc_d    = '0;
            end else if (pc_q == PC_LAST) begin
               duty_d = diff[WIDTH] ? duty_q - 1'b1 : duty_q + 1'b1;
               pc_d   = '0;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
      end
      // Compare on the post-update slot and duty so the new period starts clean.
      pwm_d = (cnt_d < duty_d);
   end

   always_ff @(posedge clk) begin
      if (reset_central) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         pc_q    <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
         ps_q    <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         ps_q    <= ps_d;
         lock_q  <= lock_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign duty_cur     = duty_q;
   assign locked       = lock_q;

endmodule
